uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//   Round-robin scheduler that shares one 8-bit UART transmitter between N_REQ requesters.
//   Picks one pending byte, loads tx_data, then launches the transmitter with a rising edge on tx_start.
//   Tracks the transmitter's busy flag through the frame and returns to arbitration when it clears.
//   Sits between the requester logic and the UART transmitter, all on the UART clock clk.
// PARAMETERS
//   N_REQ          4    number of requesters (2..8)
//   LAUNCH_TMO     8    clk cycles allowed from tx_start rise to tx_busy high
//   FRAME_TMO      255  clk cycles allowed with tx_busy high before the frame is abandoned
//   GAP_CYC        2    minimum clk cycles tx_start is held low between launches (>=2)
// PORTS
//   clk          in   1         UART clock; all logic on posedge
//   rst          in   1         asynchronous, active-low reset
//   req_valid    in   N_REQ     requester i has a byte pending; held until req_ack[i]
//   req_data     in   8*N_REQ   byte of requester i at [8*i+7:8*i]; stable while req_valid[i]
//   req_ack      out  N_REQ     one-cycle pulse: byte of requester i accepted
//   tx_busy      in   1         transmitter status: 1 = frame in progress, 0 = line free
//   tx_data      out  8         byte presented to transmitter; stable from ARB until return to IDLE
//   tx_start     out  1         launch command; transmitter acts on its rising edge
//   grant_id     out  3         index of requester owning the current frame
//   frame_done   out  1         one-cycle pulse: frame completed normally (tx_busy fell)
//   err_tmo      out  1         one-cycle pulse: launch or frame timeout; byte is dropped, not retried
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, req_ack=0, frame_done=0, err_tmo=0, counters=0.
//   Reset is honoured in any state. A frame cut by reset is not resumed or acked.
//   FSM states: IDLE, ARB, LAUNCH, SEND, GAP. All outputs are registered.
//   IDLE: if |req_valid and tx_busy=0, go to ARB next cycle. Otherwise stay; tx_start=0.
//   ARB (1 cycle):
//     - Grant the first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//     - Latch its byte into tx_data and its index into grant_id.
//     - Pulse req_ack[g] (visible the cycle after ARB; only one ack bit ever set).
//     - Set rr_ptr = (g+1) mod N_REQ. Go to LAUNCH.
//   LAUNCH:
//     - tx_start=1 and cnt counts up from 0.
//     - tx_busy=1: go to SEND and clear cnt (tx_start may drop).
//     - cnt reaches LAUNCH_TMO-1 with tx_busy still 0: pulse err_tmo, go to GAP.
//   SEND:
//     - tx_start=0 and cnt counts.
//     - tx_busy=0: pulse frame_done, go to GAP.
//     - cnt reaches FRAME_TMO-1 with tx_busy still 1: pulse err_tmo, go to GAP.
//     - frame_done and err_tmo never assert together.
//   GAP:
//     - tx_start=0 for GAP_CYC cycles, so the next rising edge is seen by the 2-flop edge detector.
//     - Then go to IDLE. Arbitration never bypasses GAP.
//   Requests that assert during LAUNCH/SEND/GAP wait. A req_valid dropped before ack is simply not granted.
//   Simultaneous requests: strict round-robin; each requester gets at most one frame before a waiting peer is served.
//   tx_busy=1 on entry to IDLE (line held by someone else): remain in IDLE, no grant.
//   rr_ptr wraps N_REQ-1 -> 0. cnt width is clog2(max(LAUNCH_TMO,FRAME_TMO)+1) and never wraps.
//   Best-case launch latency: req_valid high in IDLE -> tx_start high 2 cycles later.
// TESTING
//   1. Single request: req_valid=0001, data0=8'hA5, model busy 3 cycles after tx_start rise for 169 cycles
//      -> tx_data=A5, req_ack=0001 once, frame_done once, tx_start low >=2 cycles after.
//   2. All four requests held valid with data 11/22/33/44 -> frames sent in order 0,1,2,3.
//      Then re-request 0 and 2 -> order 0,2. grant_id tracks each frame.
//   3. Busy never asserts -> err_tmo pulses exactly LAUNCH_TMO cycles after tx_start rise; FSM back in IDLE after GAP; no frame_done.
//   4. Busy stuck high after launch -> err_tmo after FRAME_TMO cycles in SEND; next request is still served.
//   5. Assert rst low mid-SEND -> all outputs at reset values next cycle. After release, the first grant goes to requester 0.
//   6. tx_busy=1 while in IDLE with req_valid=0010 -> no ack until tx_busy=0, then ack in 2 cycles.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the requesters, the round-robin scheduler and the UART transmitter.
interface uart_tx_sched_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ack;
   logic               tx_busy;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic [2:0]         grant_id;
   logic               frame_done;
   logic               err_tmo;

   modport master (
      input  req_valid, req_data, tx_busy,
      output req_ack, tx_data, tx_start, grant_id, frame_done, err_tmo
   );

   modport slave (
      output req_valid, req_data, tx_busy,
      input  req_ack, tx_data, tx_start, grant_id, frame_done, err_tmo
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte requesters.
// Launch via a held tx_start level, tracks tx_busy through the frame, enforces a low gap.
module uart_tx_sched #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned LAUNCH_TMO = 8,
   parameter int unsigned FRAME_TMO  = 255,
   parameter int unsigned GAP_CYC    = 2
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_sched_if.master bus
);
   localparam int unsigned TMO_MAX = (LAUNCH_TMO > FRAME_TMO) ? LAUNCH_TMO : FRAME_TMO;
   localparam int unsigned CNT_W   = $clog2(TMO_MAX + 1);
   localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TMO - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TMO - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LAUNCH,
      S_SEND,
      S_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic [2:0]       grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             done_q, done_d;
   logic             tmo_q, tmo_d;

   logic [7:0]       valid8;
   logic [63:0]      data64;
   logic [3:0]       sum;
   logic             found;
   logic [2:0]       pick;

   assign valid8 = 8'(bus.req_valid);
   assign data64 = 64'(bus.req_data);

   // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sum = {1'b0, rr_ptr_q} + 4'(i);
         if (sum >= 4'(N_REQ)) begin
            sum = sum - 4'(N_REQ);
         end
         if (!found && valid8[sum[2:0]]) begin
            found = 1'b1;
            pick  = sum[2:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      grant_d    = grant_q;
      ack_d      = '0;
      done_d     = 1'b0;
      tmo_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (|bus.req_valid && !bus.tx_busy) begin
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            cnt_d = '0;
            if (found) begin
               tx_data_d  = data64[{pick, 3'b000} +: 8];
               grant_d    = pick;
               ack_d      = N_REQ'(8'd1 << pick);
               rr_ptr_d   = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
               tx_start_d = 1'b1;
               state_d    = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            if (bus.tx_busy) begin
               cnt_d   = '0;
               state_d = S_SEND;
            end else if (cnt_q == LAUNCH_LAST) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               tx_start_d = 1'b1;
               cnt_d      = cnt_q + CNT_W'(1);
            end
         end
         S_SEND: begin
            if (!bus.tx_busy) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == FRAME_LAST) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         grant_q    <= '0;
         ack_q      <= '0;
         done_q     <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.grant_id   = grant_q;
   assign bus.req_ack    = ack_q;
   assign bus.frame_done = done_q;
   assign bus.err_tmo    = tmo_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table of request patterns, ack scoreboard, transmitter model.
module tb_uart_tx_sched;
   localparam int unsigned N_REQ      = 4;
   localparam int unsigned LAUNCH_TMO = 8;
   localparam int unsigned FRAME_TMO  = 255;
   localparam int unsigned GAP_CYC    = 2;
   localparam int          BUSY_DLY   = 3;
   localparam int          BUSY_LEN   = 169;

   typedef enum {M_NORMAL, M_NEVER, M_STUCK, M_MANUAL} mode_e;
   typedef struct packed {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [2:0]  nfr;
      logic [11:0] order;
   } vec_t;
   typedef struct packed {
      logic [2:0] id;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_sched_if #(.N_REQ(N_REQ)) bus ();

   uart_tx_sched #(
      .N_REQ(N_REQ),
      .LAUNCH_TMO(LAUNCH_TMO),
      .FRAME_TMO(FRAME_TMO),
      .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   exp_t  sb[$];
   vec_t  vecs[6];
   mode_e mode = M_NORMAL;
   int    busy_delay = -1;
   int    busy_left = 0;
   int    busy_rise_cyc = 0;
   int    fall_cyc = 0;
   int    rise_cyc = 0;
   int    err_cyc = 0;
   int    ack_cyc = 0;
   int    ack_cnt = 0;
   int    done_cnt = 0;
   int    err_cnt = 0;
   int    low_run = 0;
   bit    launched = 1'b0;
   logic  prev_start = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample DUT just after the edge, score it, then advance the transmitter model.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.tx_start && !prev_start) begin
         if (launched) check("start_low_gap", 32'(low_run >= 2), 1);
         launched = 1'b1;
         rise_cyc = cyc;
         if (mode == M_NORMAL || mode == M_STUCK) busy_delay = BUSY_DLY;
      end
      low_run    = bus.tx_start ? 0 : low_run + 1;
      prev_start = bus.tx_start;
      if (|bus.req_ack) begin
         ack_cnt++;
         ack_cyc = cyc;
         check("ack_onehot", 32'($countones(bus.req_ack)), 1);
         if (sb.size() == 0) begin
            check("ack_unexpected", 32'(bus.req_ack), 0);
         end else begin
            e = sb.pop_front();
            check("ack_id", 32'(bus.req_ack), 32'(4'b0001 << e.id));
            check("grant_id", 32'(bus.grant_id), 32'(e.id));
            check("tx_data", 32'(bus.tx_data), 32'(e.data));
         end
         bus.req_valid = bus.req_valid & ~bus.req_ack;
      end
      if (bus.frame_done) begin
         done_cnt++;
         check("done_after_busy_fall", 32'(cyc - fall_cyc), 1);
      end
      if (bus.err_tmo) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.frame_done || bus.err_tmo) check("done_err_exclusive", 32'(bus.frame_done & bus.err_tmo), 0);
      if (busy_delay > 0) begin
         busy_delay--;
         if (busy_delay == 0) begin
            bus.tx_busy   = 1'b1;
            busy_left     = BUSY_LEN;
            busy_rise_cyc = cyc;
            busy_delay    = -1;
         end
      end else if (mode == M_NORMAL && bus.tx_busy) begin
         busy_left--;
         if (busy_left == 0) begin
            bus.tx_busy = 1'b0;
            fall_cyc    = cyc;
         end
      end
   endtask

   task automatic push_exp(input logic [2:0] id, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.data = data[8*id +: 8];
      sb.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      int done0 = done_cnt;
      int err0  = err_cnt;
      for (int k = 0; k < int'(v.nfr); k++) push_exp(v.order[3*k +: 3], v.data);
      bus.req_data  = v.data;
      bus.req_valid = v.valid;
      for (int n = 0; n < 400 * int'(v.nfr) && done_cnt < done0 + int'(v.nfr); n++) tick();
      repeat (4) tick();
      check("frames_done", 32'(done_cnt - done0), 32'(v.nfr));
      check("sb_drained", 32'(sb.size()), 0);
      check("no_err_tmo", 32'(err_cnt - err0), 0);
   endtask

   initial begin
      int   done0;
      int   err0;
      int   ack0;
      int   t0;
      vec_t v;

      // order field: slot k at [3k+:3]; expectations follow rr_ptr from reset.
      vecs[0] = '{valid: 4'b1111, data: 32'h4433_2211, nfr: 3'd4, order: {3'd3, 3'd2, 3'd1, 3'd0}};
      vecs[1] = '{valid: 4'b0101, data: 32'h00C3_005A, nfr: 3'd2, order: {3'd0, 3'd0, 3'd2, 3'd0}};
      vecs[2] = '{valid: 4'b0001, data: 32'h0000_00A5, nfr: 3'd1, order: {3'd0, 3'd0, 3'd0, 3'd0}};
      vecs[3] = '{valid: 4'b1001, data: 32'hF000_000F, nfr: 3'd2, order: {3'd0, 3'd0, 3'd0, 3'd3}};
      vecs[4] = '{valid: 4'b0110, data: 32'h007E_8100, nfr: 3'd2, order: {3'd0, 3'd0, 3'd2, 3'd1}};
      vecs[5] = '{valid: 4'b1010, data: 32'hE100_1E00, nfr: 3'd2, order: {3'd0, 3'd0, 3'd1, 3'd3}};

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy   = 1'b0;
      rst           = 1'b0;
      tick();
      tick();
      check("reset_outputs", 32'({bus.tx_start, bus.tx_data, bus.grant_id, bus.req_ack,
                                  bus.frame_done, bus.err_tmo}), 0);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Line held busy by someone else: no grant until it frees, then ack two cycles later.
      mode        = M_MANUAL;
      bus.tx_busy = 1'b1;
      push_exp(3'd1, 32'h0000_6D00);
      bus.req_data  = 32'h0000_6D00;
      bus.req_valid = 4'b0010;
      ack0 = ack_cnt;
      repeat (10) tick();
      check("no_ack_while_busy", 32'(ack_cnt - ack0), 0);
      mode        = M_NORMAL;
      bus.tx_busy = 1'b0;
      t0          = cyc;
      for (int n = 0; n < 20 && ack_cnt == ack0; n++) tick();
      check("ack_after_busy_free", 32'(ack_cnt - ack0), 1);
      check("ack_latency", 32'(ack_cyc - t0), 2);
      done0 = done_cnt;
      for (int n = 0; n < 400 && done_cnt == done0; n++) tick();
      check("busy_case_frame", 32'(done_cnt - done0), 1);
      repeat (4) tick();

      // Transmitter never answers: launch timeout, then GAP before the next grant.
      mode  = M_NEVER;
      done0 = done_cnt;
      err0  = err_cnt;
      push_exp(3'd2, 32'h003C_0000);
      bus.req_data  = 32'h003C_0000;
      bus.req_valid = 4'b0100;
      for (int n = 0; n < 200 && err_cnt == err0; n++) tick();
      check("launch_tmo_seen", 32'(err_cnt - err0), 1);
      check("launch_tmo_latency", 32'(err_cyc - rise_cyc), LAUNCH_TMO);
      check("launch_tmo_no_done", 32'(done_cnt - done0), 0);
      mode = M_NORMAL;
      push_exp(3'd0, 32'h0000_0099);
      bus.req_data  = 32'h0000_0099;
      bus.req_valid = 4'b0001;
      ack0 = ack_cnt;
      t0   = err_cyc;
      for (int n = 0; n < 40 && ack_cnt == ack0; n++) tick();
      check("grant_after_gap", 32'(ack_cyc - t0), GAP_CYC + 2);
      for (int n = 0; n < 400 && done_cnt == done0; n++) tick();
      check("frame_after_launch_tmo", 32'(done_cnt - done0), 1);
      repeat (4) tick();

      // Busy stuck high: frame abandoned FRAME_TMO cycles into SEND, next request still served.
      mode  = M_STUCK;
      done0 = done_cnt;
      err0  = err_cnt;
      push_exp(3'd3, 32'h5E00_0000);
      bus.req_data  = 32'h5E00_0000;
      bus.req_valid = 4'b1000;
      for (int n = 0; n < 600 && err_cnt == err0; n++) tick();
      check("frame_tmo_seen", 32'(err_cnt - err0), 1);
      check("frame_tmo_latency", 32'(err_cyc - busy_rise_cyc), FRAME_TMO + 1);
      check("frame_tmo_no_done", 32'(done_cnt - done0), 0);
      mode        = M_NORMAL;
      bus.tx_busy = 1'b0;
      busy_delay  = -1;
      fall_cyc    = cyc;
      repeat (4) tick();
      v = '{valid: 4'b0001, data: 32'h0000_0077, nfr: 3'd1, order: 12'd0};
      run_vec(v);

      // Reset mid-frame: outputs clear, cut frame is neither finished nor resumed.
      push_exp(3'd2, 32'h00B4_0000);
      bus.req_data  = 32'h00B4_0000;
      bus.req_valid = 4'b0100;
      for (int n = 0; n < 100 && !bus.tx_busy; n++) tick();
      check("reached_send", 32'(bus.tx_busy), 1);
      repeat (20) tick();
      bus.req_data  = 32'h00D2_00C1;
      bus.req_valid = 4'b0101;
      rst           = 1'b0;
      tick();
      check("midframe_reset_outputs", 32'({bus.tx_start, bus.tx_data, bus.grant_id, bus.req_ack,
                                           bus.frame_done, bus.err_tmo}), 0);
      bus.tx_busy = 1'b0;
      busy_delay  = -1;
      fall_cyc    = cyc;
      done0       = done_cnt;
      tick();
      push_exp(3'd0, 32'h00D2_00C1);
      push_exp(3'd2, 32'h00D2_00C1);
      rst = 1'b1;
      for (int n = 0; n < 900 && done_cnt < done0 + 2; n++) tick();
      repeat (4) tick();
      check("post_reset_frames", 32'(done_cnt - done0), 2);
      check("post_reset_sb_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
